// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI request arbiter: FSM states and the latched command word.
// No logic, so no latency; the package has no backpressure of its own.
package spi_arb_pkg;

    localparam int SPI_AW = 8;
    localparam int SPI_DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_t;

    // Command word at the default widths; the arbiter builds the same layout at its own AW/DW.
    typedef struct packed {
        logic              wr;
        logic [SPI_AW-1:0] addr;
        logic [SPI_DW-1:0] wdata;
    } spi_cmd_t;

endpackage

// File: rtl/spi_req_arbiter_rr_picker.sv
// Round-robin first-set search: lowest set request at or above ptr, wrapping at N.
// Purely combinational (zero latency); it never stalls, callers gate on any_req.
module rr_picker
    import spi_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] winner,
    output logic                 any_req
);

    localparam int IW = $clog2(N);

    int          idx;
    logic [IW-1:0] idx_w;

    // Wrap is done with an explicit modulo so non-power-of-two N never aliases.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int k = 0; k < N; k++) begin
            idx   = (int'(ptr) + k) % N;
            idx_w = IW'(idx);
            if (!any_req && req[idx_w]) begin
                any_req = 1'b1;
                winner  = idx_w;
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin share of one SPI master among N_REQ requesters; optional WAIT timeout under SPI_ARB_TIMEOUT_EN.
// Latency: ready 1 cycle after request seen in IDLE, spi_start 1 later, resp_valid 1 cycle after spi_done.
// Backpressure: requesters hold valid/payload until their one-cycle ready; only one transaction in flight.
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int AW          = SPI_AW,
    parameter int DW          = SPI_DW,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0]         req_wr,
    input  logic [N_REQ*AW-1:0]      req_addr,
    input  logic [N_REQ*DW-1:0]      req_wdata,
    output logic [N_REQ-1:0]         resp_valid,
    output logic [DW-1:0]            resp_rdata,
    output logic                     resp_err,
    output logic                     spi_start,
    output logic                     spi_wr,
    output logic [AW-1:0]            spi_addr,
    output logic [DW-1:0]            spi_wdata,
    input  logic                     spi_done,
    input  logic [DW-1:0]            spi_rdata,
    input  logic                     spi_err,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id
);

    localparam int IW = $clog2(N_REQ);

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    arb_state_t     state;
    arb_state_t     state_nxt;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  winner;
    logic           any_req;
    cmd_t           cmd_q;
    cmd_t           pick_cmd;
    logic [N_REQ-1:0] win_hot;
    logic [N_REQ-1:0] grant_hot;
    logic [IW-1:0]  ptr_after;
    logic           tmo_hit;

    rr_picker #(.N(N_REQ)) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        pick_cmd.wr    = req_wr[winner];
        pick_cmd.addr  = req_addr[int'(winner)*AW +: AW];
        pick_cmd.wdata = req_wdata[int'(winner)*DW +: DW];
        win_hot        = N_REQ'(1) << winner;
        grant_hot      = N_REQ'(1) << grant_id;
        ptr_after      = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            tmo_cnt <= '0;
        end else if (state == ST_WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state == ST_WAIT) && !spi_done && (tmo_cnt == TW'(TIMEOUT_CYC));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (any_req) state_nxt = ST_GRANT;
            ST_GRANT: state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (spi_done || tmo_hit) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are produced one state ahead so every output comes straight off a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            cmd_q      <= '0;
            req_ready  <= '0;
            spi_start  <= 1'b0;
            resp_valid <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt != ST_IDLE);
            req_ready  <= '0;
            spi_start  <= 1'b0;
            resp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_id  <= winner;
                        cmd_q     <= pick_cmd;
                        req_ready <= win_hot;
                    end
                end
                ST_GRANT: spi_start <= 1'b1;
                ST_WAIT: begin
                    if (spi_done) begin
                        resp_valid <= grant_hot;
                        resp_rdata <= cmd_q.wr ? '0 : spi_rdata;
                        resp_err   <= spi_err;
                    end else if (tmo_hit) begin
                        resp_valid <= grant_hot;
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                    end
                end
                ST_RESP: rr_ptr <= ptr_after;
                default: ;
            endcase
        end
    end

    assign spi_wr    = cmd_q.wr;
    assign spi_addr  = cmd_q.addr;
    assign spi_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter: grants, SPI commands and responses are queued when requests are posted.
module tb_spi_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    typedef struct {
        int         id;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       err;
    } txn_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_rdata;
    logic            resp_err;
    logic            spi_start;
    logic            spi_wr;
    logic [AW-1:0]   spi_addr;
    logic [DW-1:0]   spi_wdata;
    logic            spi_done;
    logic [DW-1:0]   spi_rdata;
    logic            spi_err;
    logic            busy;
    logic [1:0]      grant_id;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    txn_t cmd_exp[$];
    txn_t resp_exp[$];
    int   grant_exp[$];

    int         cnt[N] = '{default: 0};
    logic       r_wr[N] = '{default: 1'b0};
    logic [7:0] r_addr[N] = '{default: 8'h00};
    logic [7:0] r_wdata[N] = '{default: 8'h00};

    bit no_resp = 1'b0;
    int lat = 3;
    int ready_cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int resp_cyc = 0;

    spi_req_arbiter #(
        .N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT_CYC(20)
    ) dut (
        .clk        (clk),
        .rst        (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .spi_start  (spi_start),
        .spi_wr     (spi_wr),
        .spi_addr   (spi_addr),
        .spi_wdata  (spi_wdata),
        .spi_done   (spi_done),
        .spi_rdata  (spi_rdata),
        .spi_err    (spi_err),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [7:0] rd_model(input logic [7:0] a);
        return a ^ 8'h99;
    endfunction

    function automatic logic err_model(input logic [7:0] a);
        return a[7:4] == 4'hE;
    endfunction

    task automatic expect_txn(input int id, input logic wr, input logic [7:0] a, input logic [7:0] d,
                              input bit with_resp);
        txn_t t;
        t.id = id; t.wr = wr; t.addr = a; t.wdata = d;
        t.rdata = wr ? 8'h00 : rd_model(a);
        t.err = err_model(a);
        grant_exp.push_back(id);
        cmd_exp.push_back(t);
        if (with_resp) resp_exp.push_back(t);
    endtask

    task automatic post(input int i, input int n, input logic wr, input logic [7:0] a, input logic [7:0] d);
        cnt[i] = n; r_wr[i] = wr; r_addr[i] = a; r_wdata[i] = d;
    endtask

    function automatic int pending();
        return grant_exp.size() + cmd_exp.size() + resp_exp.size();
    endfunction

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (pending() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq(tag, pending(), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
    endtask

    // Requesters: hold valid/payload until ready, then advance to the next op.
    initial begin
        req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (rst_n && req_ready[i] && cnt[i] > 0) begin
                    cnt[i]--;
                    r_addr[i] = r_addr[i] + 8'd1;
                    r_wdata[i] = r_wdata[i] + 8'd3;
                end
                req_valid[i] = (cnt[i] > 0);
                req_wr[i] = r_wr[i];
                req_addr[i*AW +: AW] = r_addr[i];
                req_wdata[i*DW +: DW] = r_wdata[i];
            end
        end
    end

    // SPI master model: checks each launched command, holds it stable, then answers.
    initial begin
        txn_t e;
        spi_done = 1'b0; spi_rdata = '0; spi_err = 1'b0;
        forever begin
            @(negedge clk);
            if (spi_start) begin
                start_cyc = cyc;
                if (cmd_exp.size() == 0) begin
                    check_eq("unexp_start", 32'(spi_start), 0);
                end else begin
                    e = cmd_exp.pop_front();
                    check_eq("spi_cmd", 32'({spi_wr, spi_addr, spi_wdata}), 32'({e.wr, e.addr, e.wdata}));
                    if (!no_resp) begin
                        for (int c = 0; c < lat; c++) begin
                            @(negedge clk);
                            check_eq("spi_hold", 32'({spi_start, spi_wr, spi_addr, spi_wdata}),
                                     32'({1'b0, e.wr, e.addr, e.wdata}));
                        end
                        done_cyc = cyc;
                        spi_done = 1'b1;
                        spi_rdata = e.wr ? 8'h33 : rd_model(e.addr);
                        spi_err = err_model(e.addr);
                        @(negedge clk);
                        spi_done = 1'b0; spi_rdata = '0; spi_err = 1'b0;
                    end
                end
            end
        end
    end

    // Grant and response monitor.
    initial begin
        int   g;
        txn_t r;
        forever begin
            @(negedge clk);
            if (rst_n && req_ready != '0) begin
                ready_cyc = cyc;
                if (grant_exp.size() == 0) begin
                    check_eq("unexp_ready", 32'(req_ready), 0);
                end else begin
                    g = grant_exp.pop_front();
                    check_eq("req_ready", 32'(req_ready), 32'(1) << g);
                    check_eq("grant_id", 32'(grant_id), g);
                end
            end
            if (rst_n && resp_valid != '0) begin
                resp_cyc = cyc;
                if (resp_exp.size() == 0) begin
                    check_eq("unexp_resp", 32'(resp_valid), 0);
                end else begin
                    r = resp_exp.pop_front();
                    check_eq("resp_valid", 32'(resp_valid), 32'(1) << r.id);
                    check_eq("resp_rdata", 32'(resp_rdata), 32'(r.rdata));
                    check_eq("resp_err", 32'(resp_err), 32'(r.err));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_outs", 32'({req_ready, resp_valid, spi_start, spi_wr, spi_addr, spi_wdata}), 0);
        check_eq("rst_grant", 32'(grant_id), 0);
        check_eq("rst_resp", 32'({resp_rdata, resp_err}), 0);
        @(negedge clk) rst_n = 1'b1;

        // All four requesters writing: grant order 0,1,2,3,0.
        @(posedge clk); #2;
        post(0, 2, 1'b1, 8'h80, 8'h11);
        post(1, 1, 1'b1, 8'h90, 8'h22);
        post(2, 1, 1'b1, 8'hA0, 8'h33);
        post(3, 1, 1'b1, 8'hB0, 8'h44);
        expect_txn(0, 1'b1, 8'h80, 8'h11, 1'b1);
        expect_txn(1, 1'b1, 8'h90, 8'h22, 1'b1);
        expect_txn(2, 1'b1, 8'hA0, 8'h33, 1'b1);
        expect_txn(3, 1'b1, 8'hB0, 8'h44, 1'b1);
        expect_txn(0, 1'b1, 8'h81, 8'h14, 1'b1);
        drain("rr", 400);

        // Single read from requester 2, master answers 10 cycles after start.
        lat = 10;
        @(posedge clk); #2;
        post(2, 1, 1'b0, 8'h3C, 8'h00);
        expect_txn(2, 1'b0, 8'h3C, 8'h00, 1'b1);
        drain("rd", 200);
        check_eq("lat_start", start_cyc - ready_cyc, 1);
        check_eq("lat_resp", resp_cyc - done_cyc, 1);

        // Write integrity: data held through WAIT, read data forced to zero.
        lat = 6;
        @(posedge clk); #2;
        post(1, 1, 1'b1, 8'h10, 8'h5A);
        expect_txn(1, 1'b1, 8'h10, 8'h5A, 1'b1);
        drain("wr", 200);

        // Error passthrough to requester 2 only.
        lat = 2;
        @(posedge clk); #2;
        post(2, 1, 1'b0, 8'hE7, 8'h00);
        expect_txn(2, 1'b0, 8'hE7, 8'h00, 1'b1);
        drain("err", 200);

        // Reset during WAIT: response lost, stale done ignored, pointer back to 0.
        no_resp = 1'b1;
        @(posedge clk); #2;
        post(3, 1, 1'b0, 8'h44, 8'h00);
        expect_txn(3, 1'b0, 8'h44, 8'h00, 1'b0);
        for (int n = 0; n < 50 && cmd_exp.size() != 0; n++) @(posedge clk);
        check_eq("mid_start_seen", cmd_exp.size(), 0);
        repeat (3) @(posedge clk);
        #3;
        check_eq("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_outs", 32'({req_ready, resp_valid, spi_start, busy, resp_err}), 0);
        check_eq("mid_rst_cmd", 32'({spi_wr, spi_addr, spi_wdata}), 0);
        check_eq("mid_rst_data", 32'({grant_id, resp_rdata}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) begin spi_done = 1'b1; spi_rdata = 8'hFF; end
        @(negedge clk) begin spi_done = 1'b0; spi_rdata = 8'h00; end
        repeat (5) @(posedge clk);
        #1;
        check_eq("stale_busy", 32'(busy), 0);
        check_eq("stale_resp", 32'(resp_valid), 0);
        no_resp = 1'b0;
        lat = 1;

        @(posedge clk); #2;
        for (int i = 0; i < N; i++) post(i, 1, 1'b0, 8'h50 + 8'(i), 8'h00);
        for (int i = 0; i < N; i++) expect_txn(i, 1'b0, 8'h50 + 8'(i), 8'h00, 1'b1);
        drain("post_rst", 400);

`ifdef SPI_ARB_TIMEOUT_EN
        begin
            txn_t t;
            no_resp = 1'b1;
            @(posedge clk); #2;
            post(0, 1, 1'b0, 8'h21, 8'h00);
            t.id = 0; t.wr = 1'b0; t.addr = 8'h21; t.wdata = 8'h00; t.rdata = 8'h00; t.err = 1'b1;
            grant_exp.push_back(0);
            cmd_exp.push_back(t);
            resp_exp.push_back(t);
            drain("tmo", 200);
            check_eq("tmo_lat", 32'((resp_cyc - start_cyc) >= 21 && (resp_cyc - start_cyc) <= 22), 1);
            no_resp = 1'b0;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
